// File: rtl/led_matrix_pkg.sv
// Shared constants, types and helpers for the 8x8 LED matrix scan controller.
package led_matrix_pkg;

  localparam int LED_ROWS   = 8;
  localparam int LED_COLS   = 8;
  localparam int PWM_PHASES = 16;
  localparam int FRAME_W    = 64;

  typedef logic [FRAME_W-1:0]  frame_t;
  typedef logic [LED_COLS-1:0] row_bits_t;
  typedef logic [2:0]          row_idx_t;

  // Row r of a frame occupies bits [8r+7:8r]; bit c is column c.
  function automatic row_bits_t row_slice(input frame_t frame, input row_idx_t row);
    return frame[int'(row)*LED_COLS +: LED_COLS];
  endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_timebase.sv
// Row-slot timebase: prescaler, PWM phase, row counter and frame wrap strobe.
module scan_timebase
  import led_matrix_pkg::*;
#(
  parameter int PRESCALE = 1024,
  parameter int PHASES   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  output logic [$clog2(PRESCALE)-1:0] cnt_o,
  output logic [$clog2(PHASES)-1:0]   phase_o,
  output logic                        tick_o,
  output row_idx_t                    row_idx_o,
  output logic                        frame_wrap_o
);

  localparam int CW   = $clog2(PRESCALE);
  localparam int PW   = $clog2(PHASES);
  localparam int SLOT = PRESCALE / PHASES;

  logic [CW-1:0] cnt_q, cnt_d;
  row_idx_t      row_q, row_d;

  assign tick_o       = enable_i && (cnt_q == CW'(PRESCALE - 1));
  assign frame_wrap_o = tick_o && (row_q == 3'd7);
  assign phase_o      = PW'(cnt_q / CW'(SLOT));
  assign cnt_o        = cnt_q;
  assign row_idx_o    = row_q;

  // Disabled means parked at row 0, count 0 so a re-enable starts a clean frame.
  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    if (!enable_i) begin
      cnt_d = '0;
      row_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
      row_d = row_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Double-buffered 8x8 LED matrix scanner with per-frame PWM brightness.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int PRESCALE   = 1024,
  parameter int PWM_PHASES = 16
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_ENABLE,
  input  logic [63:0] i_FRAME,
  input  logic        i_FRAME_VALID,
  output logic        o_FRAME_READY,
  input  logic [3:0]  i_BRIGHT,
  output logic [7:0]  o_ROWS,
  output logic [7:0]  o_COLS,
  output logic [2:0]  o_ROW_IDX,
  output logic        o_FRAME_START
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;
  logic [3:0]    phase;
  logic          tick;
  row_idx_t      rowIdx;
  logic          frameWrap;
  logic          unusedTick;

  scan_timebase #(
    .PRESCALE (PRESCALE),
    .PHASES   (PWM_PHASES)
  ) u_timebase (
    .clk_i        (i_CLK),
    .rst_n_i      (i_RST_N),
    .enable_i     (i_ENABLE),
    .cnt_o        (cnt),
    .phase_o      (phase),
    .tick_o       (tick),
    .row_idx_o    (rowIdx),
    .frame_wrap_o (frameWrap)
  );

  assign unusedTick = tick;

  frame_t     pending_q, pending_d;
  frame_t     active_q, active_d;
  logic       pendFull_q, pendFull_d;
  logic [3:0] bright_q, bright_d;
  logic       enablePrev_q;
  logic       frameStart_q, frameStart_d;
  logic [7:0] rows_q, rows_d;
  logic [7:0] cols_q, cols_d;
  row_idx_t   rowIdx_q, rowIdx_d;

  logic accept;
  logic loadEvt;

  assign o_FRAME_READY = !pendFull_q && i_RST_N;
  assign accept        = i_FRAME_VALID && o_FRAME_READY;
  // While dark there is no frame to tear, so a pending frame swaps in at once.
  assign loadEvt       = frameWrap || (!i_ENABLE && pendFull_q);

  always_comb begin
    pending_d  = pending_q;
    pendFull_d = pendFull_q;
    active_d   = active_q;
    bright_d   = bright_q;
    if (accept) begin
      pending_d  = i_FRAME;
      pendFull_d = 1'b1;
    end
    if (loadEvt) begin
      bright_d = i_BRIGHT;
      if (pendFull_q) begin
        active_d   = pending_q;
        pendFull_d = 1'b0;
      end
    end
  end

  // Drive pins from pre-edge scan state; the cnt==0 slot is a blanking gap.
  always_comb begin
    rows_d       = '0;
    cols_d       = '0;
    rowIdx_d     = '0;
    frameStart_d = frameWrap || (i_ENABLE && !enablePrev_q);
    if (i_ENABLE) begin
      rowIdx_d = rowIdx;
      if (cnt != '0) begin
        rows_d = 8'b1 << rowIdx;
        if (phase < bright_q) begin
          cols_d = row_slice(active_q, rowIdx);
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      pending_q    <= '0;
      pendFull_q   <= 1'b0;
      active_q     <= '0;
      bright_q     <= '0;
      enablePrev_q <= 1'b0;
      frameStart_q <= 1'b0;
      rows_q       <= '0;
      cols_q       <= '0;
      rowIdx_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      pendFull_q   <= pendFull_d;
      active_q     <= active_d;
      bright_q     <= bright_d;
      enablePrev_q <= i_ENABLE;
      frameStart_q <= frameStart_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      rowIdx_q     <= rowIdx_d;
    end
  end

  assign o_ROWS        = rows_q;
  assign o_COLS        = cols_q;
  assign o_ROW_IDX     = rowIdx_q;
  assign o_FRAME_START = frameStart_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed self-checking bench for led_matrix_scan_ctrl at PRESCALE = 32.
module tb_led_matrix_scan_ctrl;

  localparam int PRESCALE = 32;

  logic        i_CLK = 1'b0;
  logic        i_RST_N;
  logic        i_ENABLE;
  logic [63:0] i_FRAME;
  logic        i_FRAME_VALID;
  logic        o_FRAME_READY;
  logic [3:0]  i_BRIGHT;
  logic [7:0]  o_ROWS;
  logic [7:0]  o_COLS;
  logic [2:0]  o_ROW_IDX;
  logic        o_FRAME_START;

  int checks = 0;
  int errors = 0;
  int scanPos = -1;
  int fsCount = 0;

  localparam logic [63:0] F1 = 64'h8040201008040201;
  localparam logic [63:0] FA = 64'h0102030405060708;
  localparam logic [63:0] FB = 64'hF0E0D0C0B0A09080;
  localparam logic [63:0] FC = 64'h55AA55AA55AA55AA;
  localparam logic [63:0] FD = 64'hFFFFFFFFFFFFFFFF;

  led_matrix_scan_ctrl #(.PRESCALE(PRESCALE), .PWM_PHASES(16)) dut (
    .i_CLK         (i_CLK),
    .i_RST_N       (i_RST_N),
    .i_ENABLE      (i_ENABLE),
    .i_FRAME       (i_FRAME),
    .i_FRAME_VALID (i_FRAME_VALID),
    .o_FRAME_READY (o_FRAME_READY),
    .i_BRIGHT      (i_BRIGHT),
    .o_ROWS        (o_ROWS),
    .o_COLS        (o_COLS),
    .o_ROW_IDX     (o_ROW_IDX),
    .o_FRAME_START (o_FRAME_START)
  );

  always #5 i_CLK = ~i_CLK;

  // One rising edge; scanPos is the linear scan position sampled by that edge.
  task automatic step();
    logic en;
    en = i_ENABLE;
    @(negedge i_CLK);
    if (en) scanPos++;
    if (o_FRAME_START) fsCount++;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (scanPos < target && guard < 4000) begin
      step();
      guard++;
    end
    checks++;
    if (scanPos !== target) begin
      errors++;
      $display("[TB] FAIL run_to position got %0d want %0d", scanPos, target);
    end
  endtask

  task automatic count_cols(input int n, output int nz);
    nz = 0;
    repeat (n) begin
      step();
      if (o_COLS != 8'h00) nz++;
    end
  endtask

  task automatic test_reset();
    i_RST_N = 1'b0; i_ENABLE = 1'b0; i_FRAME = '0; i_FRAME_VALID = 1'b0; i_BRIGHT = 4'd0;
    repeat (3) step();
    checks++;
    if (o_FRAME_READY !== 1'b0) begin
      errors++; $display("[TB] FAIL ready_in_reset got %0b want 0", o_FRAME_READY);
    end
    checks++;
    if (o_ROWS !== 8'h00) begin
      errors++; $display("[TB] FAIL rows_in_reset got %0h want 00", o_ROWS);
    end
    i_RST_N = 1'b1;
    #1;
    checks++;
    if (o_FRAME_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_after_release got %0b want 1", o_FRAME_READY);
    end
    step();
    checks++;
    if (o_ROWS !== 8'h00 || o_COLS !== 8'h00 || o_ROW_IDX !== 3'd0 || o_FRAME_START !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_outputs got rows=%0h cols=%0h idx=%0d fs=%0b want 0", o_ROWS, o_COLS, o_ROW_IDX, o_FRAME_START);
    end
  endtask

  task automatic test_scan_walk();
    logic [7:0] expRows;
    i_ENABLE = 1'b1;
    scanPos = -1;
    step();
    checks++;
    if (o_FRAME_START !== 1'b1 || o_ROWS !== 8'h00) begin
      errors++; $display("[TB] FAIL enable_start got fs=%0b rows=%0h want fs=1 rows=00", o_FRAME_START, o_ROWS);
    end
    for (int r = 0; r < 8; r++) begin
      if (r > 0) begin
        run_to(32 * r);
        checks++;
        if (o_ROWS !== 8'h00) begin
          errors++; $display("[TB] FAIL dead_cycle row %0d got %0h want 00", r, o_ROWS);
        end
      end
      run_to(32 * r + 16);
      expRows = 8'h01 << r;
      checks++;
      if (o_ROWS !== expRows || o_COLS !== 8'h00 || o_ROW_IDX !== 3'(r)) begin
        errors++;
        $display("[TB] FAIL walk row %0d got rows=%0h cols=%0h idx=%0d want rows=%0h cols=00", r, o_ROWS, o_COLS, o_ROW_IDX, expRows);
      end
    end
    run_to(255);
    checks++;
    if (o_FRAME_START !== 1'b1 || o_ROWS !== 8'h80) begin
      errors++; $display("[TB] FAIL walk_wrap got fs=%0b rows=%0h want fs=1 rows=80", o_FRAME_START, o_ROWS);
    end
  endtask

  task automatic test_frame_load();
    int base;
    logic [7:0] expCols;
    i_FRAME = F1; i_FRAME_VALID = 1'b1; i_BRIGHT = 4'd15;
    checks++;
    if (o_FRAME_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL load_ready_before got %0b want 1", o_FRAME_READY);
    end
    step();
    i_FRAME_VALID = 1'b0;
    checks++;
    if (o_FRAME_READY !== 1'b0) begin
      errors++; $display("[TB] FAIL load_ready_after got %0b want 0", o_FRAME_READY);
    end
    run_to(511);
    checks++;
    if (o_FRAME_START !== 1'b1 || o_FRAME_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL load_swap got fs=%0b ready=%0b want 1 1", o_FRAME_START, o_FRAME_READY);
    end
    fsCount = 0;
    for (int k = 0; k < 3; k++) begin
      base = 512 + 32 * (3 * k + k / 2);
      expCols = 8'h01 << (3 * k + k / 2);
      run_to(base + 1);
      checks++;
      if (o_COLS !== expCols) begin
        errors++; $display("[TB] FAIL load_cols_first pos %0d got %0h want %0h", scanPos, o_COLS, expCols);
      end
      run_to(base + 29);
      checks++;
      if (o_COLS !== expCols) begin
        errors++; $display("[TB] FAIL load_cols_phase14 pos %0d got %0h want %0h", scanPos, o_COLS, expCols);
      end
      run_to(base + 30);
      checks++;
      if (o_COLS !== 8'h00) begin
        errors++; $display("[TB] FAIL load_cols_phase15 pos %0d got %0h want 00", scanPos, o_COLS);
      end
    end
    run_to(1023);
    checks++;
    if (fsCount !== 2) begin
      errors++; $display("[TB] FAIL frame_start_rate got %0d pulses want 2", fsCount);
    end
  endtask

  task automatic test_back_to_back();
    i_FRAME = FA; i_FRAME_VALID = 1'b1;
    step();
    i_FRAME = FB;
    run_to(1278);
    checks++;
    if (o_FRAME_READY !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_held got ready=%0b want 0", o_FRAME_READY);
    end
    run_to(1279);
    checks++;
    if (o_FRAME_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_after_swap got ready=%0b want 1", o_FRAME_READY);
    end
    step();
    i_FRAME_VALID = 1'b0;
    checks++;
    if (o_FRAME_READY !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_b_accepted got ready=%0b want 0", o_FRAME_READY);
    end
    run_to(1281);
    checks++;
    if (o_COLS !== 8'h08) begin
      errors++; $display("[TB] FAIL bp_a_row0 got %0h want 08", o_COLS);
    end
    run_to(1345);
    checks++;
    if (o_COLS !== 8'h06) begin
      errors++; $display("[TB] FAIL bp_a_row2 got %0h want 06", o_COLS);
    end
    run_to(1537);
    checks++;
    if (o_COLS !== 8'h80) begin
      errors++; $display("[TB] FAIL bp_b_row0 got %0h want 80", o_COLS);
    end
    run_to(1601);
    checks++;
    if (o_COLS !== 8'hA0) begin
      errors++; $display("[TB] FAIL bp_b_row2 got %0h want A0", o_COLS);
    end
  endtask

  task automatic test_brightness();
    int nz;
    int nz2;
    i_BRIGHT = 4'd4;
    run_to(1823);
    count_cols(32, nz);
    checks++;
    if (nz !== 7) begin
      errors++; $display("[TB] FAIL bright4_on_cycles got %0d want 7", nz);
    end
    i_BRIGHT = 4'd0;
    run_to(2047);
    count_cols(128, nz);
    i_BRIGHT = 4'd8;
    count_cols(128, nz2);
    checks++;
    if (nz + nz2 !== 0) begin
      errors++; $display("[TB] FAIL bright0_dark got %0d want 0", nz + nz2);
    end
    run_to(2367);
    count_cols(32, nz);
    checks++;
    if (nz !== 15) begin
      errors++; $display("[TB] FAIL bright8_on_cycles got %0d want 15", nz);
    end
  endtask

  task automatic test_enable_gating();
    i_FRAME = FC; i_FRAME_VALID = 1'b1;
    step();
    i_FRAME_VALID = 1'b0;
    run_to(2474);
    checks++;
    if (o_ROWS !== 8'h20) begin
      errors++; $display("[TB] FAIL gate_row5 got %0h want 20", o_ROWS);
    end
    fsCount = 0;
    i_ENABLE = 1'b0;
    step();
    checks++;
    if (o_ROWS !== 8'h00 || o_COLS !== 8'h00) begin
      errors++; $display("[TB] FAIL gate_dark got rows=%0h cols=%0h want 00 00", o_ROWS, o_COLS);
    end
    checks++;
    if (o_FRAME_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL gate_swap_ready got %0b want 1", o_FRAME_READY);
    end
    repeat (3) step();
    checks++;
    if (o_ROW_IDX !== 3'd0 || fsCount !== 0) begin
      errors++; $display("[TB] FAIL gate_idle got idx=%0d fs=%0d want 0 0", o_ROW_IDX, fsCount);
    end
    i_ENABLE = 1'b1;
    scanPos = -1;
    step();
    checks++;
    if (o_FRAME_START !== 1'b1 || o_ROWS !== 8'h00) begin
      errors++; $display("[TB] FAIL gate_restart got fs=%0b rows=%0h want 1 00", o_FRAME_START, o_ROWS);
    end
    step();
    checks++;
    if (o_ROWS !== 8'h01 || o_COLS !== 8'hAA || o_ROW_IDX !== 3'd0) begin
      errors++; $display("[TB] FAIL gate_new_row0 got rows=%0h cols=%0h idx=%0d want 01 AA 0", o_ROWS, o_COLS, o_ROW_IDX);
    end
    run_to(33);
    checks++;
    if (o_ROWS !== 8'h02 || o_COLS !== 8'h55) begin
      errors++; $display("[TB] FAIL gate_new_row1 got rows=%0h cols=%0h want 02 55", o_ROWS, o_COLS);
    end
  endtask

  task automatic test_reset_midframe();
    int nz;
    i_FRAME = FD; i_FRAME_VALID = 1'b1;
    step();
    i_FRAME_VALID = 1'b0;
    run_to(101);
    checks++;
    if (o_FRAME_READY !== 1'b0 || o_ROWS !== 8'h08) begin
      errors++; $display("[TB] FAIL mid_pre_reset got ready=%0b rows=%0h want 0 08", o_FRAME_READY, o_ROWS);
    end
    i_RST_N = 1'b0; i_ENABLE = 1'b0;
    step();
    checks++;
    if (o_ROWS !== 8'h00 || o_COLS !== 8'h00 || o_ROW_IDX !== 3'd0 || o_FRAME_START !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got rows=%0h cols=%0h idx=%0d fs=%0b want 0", o_ROWS, o_COLS, o_ROW_IDX, o_FRAME_START);
    end
    step();
    i_RST_N = 1'b1;
    #1;
    checks++;
    if (o_FRAME_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_release_ready got %0b want 1", o_FRAME_READY);
    end
    step();
    i_BRIGHT = 4'd15;
    i_ENABLE = 1'b1;
    scanPos = -1;
    step();
    checks++;
    if (o_FRAME_START !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_restart_fs got %0b want 1", o_FRAME_START);
    end
    run_to(255);
    count_cols(256, nz);
    checks++;
    if (nz !== 0) begin
      errors++; $display("[TB] FAIL mid_old_frame_shown got %0d lit cycles want 0", nz);
    end
  endtask

  initial begin
    test_reset();
    test_scan_walk();
    test_frame_load();
    test_back_to_back();
    test_brightness();
    test_enable_gating();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
Frame-level controller for the 8x8 LED matrix. It accepts 64-bit frames over a valid/ready handshake and double-buffers them: one pending buffer, one active buffer. It scans the active frame row by row with a programmable dwell and applies per-frame PWM brightness. Sits between pattern sources (LFSR generator, MCU bridge) and the matrix pins, replacing free-running counter-bit scan clocks.

Parameters:
PRESCALE, 1024, clock cycles per row slot; must be a multiple of 16 and at least 32.
PWM_PHASES, 16, brightness phases per row slot; fixed at 16 by the 4-bit brightness input.

Ports:
i_CLK  in  1  system clock
i_RST_N  in  1  synchronous reset, active-low
i_ENABLE  in  1  scan enable; 0 = matrix dark, timebase held
i_FRAME  in  64  frame data; bits [8r+7:8r] are row r, bit c of a row is column c, 1 = LED on
i_FRAME_VALID  in  1  frame offered
o_FRAME_READY  out  1  pending buffer empty, frame can be accepted
i_BRIGHT  in  4  duty in sixteenths, 0 = off, 15 = 15/16
o_ROWS  out  8  one-hot row select, active-high
o_COLS  out  8  column data for the selected row, active-high
o_ROW_IDX  out  3  row currently being scanned
o_FRAME_START  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (i_RST_N=0 at a rising i_CLK edge) clears:
  - prescaler, row index, active buffer, pending flag and latched brightness;
  - o_ROWS, o_COLS, o_ROW_IDX and o_FRAME_START to 0.
- o_FRAME_READY = !pend_full & i_RST_N. It reads 1 in the first cycle after reset is released. A reset mid-frame discards both buffers.
- Handshake: a frame is accepted on a rising edge where i_FRAME_VALID & o_FRAME_READY. i_FRAME is loaded into the pending buffer and pend_full is set. The source must hold valid and data stable until accepted.
- Timebase:
  - cnt runs 0..PRESCALE-1 and wraps; tick = (cnt == PRESCALE-1).
  - On tick, row_idx increments mod 8.
  - phase = cnt / (PRESCALE/16), range 0..15.
- Frame boundary (tick while row_idx == 7, i.e. the wrap to row 0):
  - If pend_full: active <= pending and pend_full is cleared.
  - bright_q <= i_BRIGHT.
  - o_FRAME_START is 1 in the following cycle.
  - Brightness and frame changes take effect only at this boundary, so there is no tearing.
- Simultaneous swap and offer: ready is 0 while pend_full, so no accept can coincide with a swap. Ready returns to 1 in the cycle after the swap.
- Outputs, registered with one cycle latency from cnt/row_idx:
  - Dead time: when cnt == 0, o_ROWS = 0 and o_COLS = 0 (anti-ghosting).
  - Otherwise o_ROWS = 1 << row_idx.
  - Otherwise o_COLS = active[8*row_idx +: 8] when phase < bright_q, else 0.
  - o_ROW_IDX = row_idx.
- i_ENABLE = 0:
  - cnt and row_idx held at 0; o_ROWS and o_COLS forced to 0; o_FRAME_START stays 0.
  - The handshake still operates. If pend_full, the swap happens on the next edge, bright_q is sampled and pend_full is cleared.
- i_ENABLE rising: scanning restarts at row 0, cnt 0. o_FRAME_START pulses in the first enabled cycle.
- Brightness arithmetic: on-time per slot = bright_q * PRESCALE/16 cycles, minus one cycle if bright_q = 0 is excluded; bright_q = 0 means no on-time at all. The dead-time cycle falls inside phase 0, so with bright_q >= 1 the on-time is bright_q*PRESCALE/16 - 1 cycles.

Decomposition:
- Shared package led_matrix_pkg, holding:
  - constants LED_ROWS = 8, LED_COLS = 8, PWM_PHASES = 16, FRAME_W = 64;
  - a function returning the 8-bit row slice of a frame.
- One sub-module, scan_timebase, with PRESCALE as a parameter. Inputs: clk, rst_n, enable. Outputs: cnt, phase, tick, row_idx, frame_wrap.
- Buffering and output gating stay in the top module.

Test Plan:
All scenarios use PRESCALE = 32.
- Reset release: after reset, o_FRAME_READY = 1 in cycle 1; o_ROWS, o_COLS and o_ROW_IDX are all 0. Enable with no frame -> o_ROWS walks 0x01..0x80, 32 cycles per row, o_COLS = 0.
- Frame load: offer frame 0x8040201008040201, bright 15 -> accepted in 1 cycle, then ready = 0. After the next wrap, row r shows o_COLS = 1<<r for phases 0..14 (dead cycle excepted) and 0 in phase 15. o_FRAME_START pulses once per 256 cycles.
- Backpressure: offer frame A, then hold frame B valid -> B stays unaccepted until the cycle after the swap of A. B is displayed exactly one frame after A; no frame is lost or repeated.
- Brightness: bright 4 -> per row, o_COLS is nonzero for exactly 7 cycles (8 minus the dead cycle). Bright 0 -> o_COLS is always 0. A change to 8 mid-frame takes effect only after the next o_FRAME_START.
- Enable gating: drop i_ENABLE at row 5 -> outputs are 0 on the next cycle. A pending frame swaps in while disabled. On re-enable, the scan restarts at row 0 with an o_FRAME_START pulse and shows the new frame.
- Reset mid-frame: assert i_RST_N = 0 at row 3 with pending full -> all outputs are 0 and ready = 1 after release; the old frame is not displayed.
